difftest_commit_buffer: RTL and testbench

// - Multi-lane successor to the single-lane negedge commit/trap logic in the sim top. Sits between core writeback and the Difftest* commit/trap ports.
// - Accepts commit groups of up to NCH in-order retirements per cycle and buffers them in a DEPTH-group FIFO.
// - Drains one group per cycle to registered per-lane commit outputs. Tracks cycle/instr counts and a sticky trap.

---
 rtl/difftest_commit_buffer_pkg.sv | 22 ++
 rtl/difftest_commit_buffer_fifo.sv | 53 +++++
 rtl/difftest_commit_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_difftest_commit_buffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_commit_buffer_pkg.sv
// Shared constants for the difftest commit buffer: trap opcode, boot pc and lane record layout.
// Optional macro DIFFTEST_SKIP_EN adds one skip bit to every lane record.
// Lane record, LSB first: wdata[XLEN] | wdest[8] | wen[1] | inst[32] | pc[XLEN] | skip[1, optional].
package difftest_commit_buffer_pkg;

    localparam logic [6:0]  TRAP_OPCODE      = 7'h6b;
    localparam logic [63:0] PC_START_DEFAULT = 64'h8000_0000;
    localparam int          INST_W           = 32;
    localparam int          WDEST_W          = 8;

`ifdef DIFFTEST_SKIP_EN
    localparam int SKIP_W = 1;
`else
    localparam int SKIP_W = 0;
`endif

    // Width of one packed lane record for a given register width.
    function automatic int lane_width(input int xlen);
        return 2 * xlen + INST_W + 1 + WDEST_W + SKIP_W;
    endfunction

endpackage

// File: rtl/difftest_commit_buffer_fifo.sv
// commit_fifo: generic synchronous FIFO of WIDTH-bit entries, DEPTH entries (power of 2, >= 2).
// Latency: a push is visible on pop_data the cycle after the write edge.
// Backpressure: full/empty come straight from the pointer registers; push when full and pop when empty are ignored.
// Ports: clock, reset (async active-low), push/push_data, pop/pop_data, full, empty, count.
module commit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer MSB tells a full ring from an empty one when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/difftest_commit_buffer.sv
// difftest_commit_buffer: buffers NCH-lane commit groups and drains one group per cycle to registered commit ports.
// Latency: group pushed at edge N appears on cmt_* at edge N+1 when the FIFO was empty and out_ready is high.
// Backpressure: in_ready = reset released && !full && !trap; no push-through when full; a trap stops push and pop until reset.
// Ports: clock, reset (async active-low); in_valid/in_ready + per-lane in_* record and in_a0; out_ready;
//        cmt_valid + per-lane cmt_* record; trap, trap_code, trap_pc; cycle_cnt, instr_cnt.
// Optional macro DIFFTEST_SKIP_EN: adds in_skip/cmt_skip carried per lane (otherwise the commit skip is always 0).
module difftest_commit_buffer
    import difftest_commit_buffer_pkg::*;
#(
    parameter int              NCH      = 2,
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_START = PC_START_DEFAULT[XLEN-1:0]
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH-1:0]        in_lane_vld,
    input  logic [NCH*XLEN-1:0]   in_pc,
    input  logic [NCH*32-1:0]     in_inst,
    input  logic [NCH-1:0]        in_wen,
    input  logic [NCH*8-1:0]      in_wdest,
    input  logic [NCH*XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]       in_a0,
`ifdef DIFFTEST_SKIP_EN
    input  logic [NCH-1:0]        in_skip,
    output logic [NCH-1:0]        cmt_skip,
`endif
    input  logic                  out_ready,
    output logic [NCH-1:0]        cmt_valid,
    output logic [NCH*XLEN-1:0]   cmt_pc,
    output logic [NCH*32-1:0]     cmt_inst,
    output logic [NCH-1:0]        cmt_wen,
    output logic [NCH*8-1:0]      cmt_wdest,
    output logic [NCH*XLEN-1:0]   cmt_wdata,
    output logic                  trap,
    output logic [7:0]            trap_code,
    output logic [XLEN-1:0]       trap_pc,
    output logic [63:0]           cycle_cnt,
    output logic [63:0]           instr_cnt
);

    // FIFO word: lane mask at the bottom, then a0, then NCH lane records.
    localparam int LW        = lane_width(XLEN);
    localparam int BASE      = NCH + XLEN;
    localparam int WIDTH     = NCH * LW + BASE;
    localparam int OFF_WDEST = XLEN;
    localparam int OFF_WEN   = XLEN + WDEST_W;
    localparam int OFF_INST  = XLEN + WDEST_W + 1;
    localparam int OFF_PC    = XLEN + WDEST_W + 1 + INST_W;
    localparam int AW        = $clog2(DEPTH);

    logic [NCH-1:0]      lane_vld;
    logic [WIDTH-1:0]    push_data;
    logic [WIDTH-1:0]    pop_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_count;
    logic                do_push;
    logic                do_pop;

    logic [NCH-1:0]      pop_mask;
    logic [NCH*XLEN-1:0] pop_pc;
    logic [NCH*32-1:0]   pop_inst;
    logic [NCH-1:0]      pop_wen;
    logic [NCH*8-1:0]    pop_wdest;
    logic [NCH*XLEN-1:0] pop_wdata;
    logic [63:0]         pop_cnt;
    logic                trap_hit;
    logic                lane_found;
    logic [XLEN-1:0]     trap_lane_pc;
`ifdef DIFFTEST_SKIP_EN
    logic [NCH-1:0]      pop_skip;
`endif

    // The core presents pc==PC_START/inst==0 on lane 0 before the first real retirement.
    always_comb begin
        lane_vld = in_lane_vld;
        if (in_pc[XLEN-1:0] == PC_START && in_inst[31:0] == 32'd0) begin
            lane_vld[0] = 1'b0;
        end
    end

    assign in_ready = reset && !fifo_full && !trap;
    // A group with no valid lane is still handshaked but never stored.
    assign do_push  = in_valid && in_ready && (|lane_vld);
    assign do_pop   = !fifo_empty && out_ready && !trap;

    always_comb begin
        push_data               = '0;
        push_data[NCH-1:0]      = lane_vld;
        push_data[NCH +: XLEN]  = in_a0;
        for (int i = 0; i < NCH; i++) begin
            push_data[BASE + i*LW +: XLEN]             = in_wdata[i*XLEN +: XLEN];
            push_data[BASE + i*LW + OFF_WDEST +: 8]    = in_wdest[i*8 +: 8];
            push_data[BASE + i*LW + OFF_WEN]           = in_wen[i];
            push_data[BASE + i*LW + OFF_INST +: 32]    = in_inst[i*32 +: 32];
            push_data[BASE + i*LW + OFF_PC +: XLEN]    = in_pc[i*XLEN +: XLEN];
`ifdef DIFFTEST_SKIP_EN
            push_data[BASE + i*LW + 2*XLEN + 41]       = in_skip[i];
`endif
        end
    end

    commit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (do_push),
        .push_data (push_data),
        .pop       (do_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        pop_mask  = pop_data[NCH-1:0];
        pop_pc    = '0;
        pop_inst  = '0;
        pop_wen   = '0;
        pop_wdest = '0;
        pop_wdata = '0;
`ifdef DIFFTEST_SKIP_EN
        pop_skip  = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            pop_wdata[i*XLEN +: XLEN] = pop_data[BASE + i*LW +: XLEN];
            pop_wdest[i*8 +: 8]       = pop_data[BASE + i*LW + OFF_WDEST +: 8];
            pop_wen[i]                = pop_data[BASE + i*LW + OFF_WEN];
            pop_inst[i*32 +: 32]      = pop_data[BASE + i*LW + OFF_INST +: 32];
            pop_pc[i*XLEN +: XLEN]    = pop_data[BASE + i*LW + OFF_PC +: XLEN];
`ifdef DIFFTEST_SKIP_EN
            pop_skip[i]               = pop_data[BASE + i*LW + 2*XLEN + 41];
`endif
        end
    end

    // Only the lowest valid lane is checked for the trap opcode; lanes above it still commit.
    always_comb begin
        trap_hit     = 1'b0;
        lane_found   = 1'b0;
        trap_lane_pc = '0;
        pop_cnt      = '0;
        for (int i = 0; i < NCH; i++) begin
            pop_cnt = pop_cnt + 64'(pop_mask[i]);
            if (!lane_found && pop_mask[i]) begin
                lane_found   = 1'b1;
                trap_hit     = (pop_inst[i*32 +: 7] == TRAP_OPCODE);
                trap_lane_pc = pop_pc[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmt_valid <= '0;
            cmt_pc    <= '0;
            cmt_inst  <= '0;
            cmt_wen   <= '0;
            cmt_wdest <= '0;
            cmt_wdata <= '0;
`ifdef DIFFTEST_SKIP_EN
            cmt_skip  <= '0;
`endif
            trap      <= 1'b0;
            trap_code <= '0;
            trap_pc   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cmt_valid <= '0;
            if (!trap) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (do_pop) begin
                cmt_valid <= pop_mask;
                cmt_pc    <= pop_pc;
                cmt_inst  <= pop_inst;
                cmt_wen   <= pop_wen;
                cmt_wdest <= pop_wdest;
                cmt_wdata <= pop_wdata;
`ifdef DIFFTEST_SKIP_EN
                cmt_skip  <= pop_skip;
`endif
                instr_cnt <= instr_cnt + pop_cnt;
                if (trap_hit) begin
                    trap      <= 1'b1;
                    trap_code <= pop_data[NCH +: 8];
                    trap_pc   <= trap_lane_pc;
                end
            end
        end
    end

    // Occupancy can never exceed the configured depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (int'(fifo_count) <= DEPTH);
        end
    end

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Testbench for difftest_commit_buffer: random and directed commit groups against a queue-level reference model.
// Expected groups go into a scoreboard when accepted; a monitor pops and compares on each commit pulse.
module tb_difftest_commit_buffer;

    localparam int              NCH      = 2;
    localparam int              DEPTH    = 4;
    localparam int              XLEN     = 64;
    localparam logic [XLEN-1:0] PC_START = 64'h8000_0000;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [NCH-1:0]        in_lane_vld = '0;
    logic [NCH*XLEN-1:0]   in_pc = '0;
    logic [NCH*32-1:0]     in_inst = '0;
    logic [NCH-1:0]        in_wen = '0;
    logic [NCH*8-1:0]      in_wdest = '0;
    logic [NCH*XLEN-1:0]   in_wdata = '0;
    logic [XLEN-1:0]       in_a0 = '0;
    logic                  out_ready = 1'b0;
    logic [NCH-1:0]        cmt_valid;
    logic [NCH*XLEN-1:0]   cmt_pc;
    logic [NCH*32-1:0]     cmt_inst;
    logic [NCH-1:0]        cmt_wen;
    logic [NCH*8-1:0]      cmt_wdest;
    logic [NCH*XLEN-1:0]   cmt_wdata;
    logic                  trap;
    logic [7:0]            trap_code;
    logic [XLEN-1:0]       trap_pc;
    logic [63:0]           cycle_cnt;
    logic [63:0]           instr_cnt;
`ifdef DIFFTEST_SKIP_EN
    logic [NCH-1:0]        in_skip = '0;
    logic [NCH-1:0]        cmt_skip;
`endif

    difftest_commit_buffer #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane_vld (in_lane_vld),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_wen      (in_wen),
        .in_wdest    (in_wdest),
        .in_wdata    (in_wdata),
        .in_a0       (in_a0),
`ifdef DIFFTEST_SKIP_EN
        .in_skip     (in_skip),
        .cmt_skip    (cmt_skip),
`endif
        .out_ready   (out_ready),
        .cmt_valid   (cmt_valid),
        .cmt_pc      (cmt_pc),
        .cmt_inst    (cmt_inst),
        .cmt_wen     (cmt_wen),
        .cmt_wdest   (cmt_wdest),
        .cmt_wdata   (cmt_wdata),
        .trap        (trap),
        .trap_code   (trap_code),
        .trap_pc     (trap_pc),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NCH-1:0]      mask;
        logic [NCH*XLEN-1:0] pc;
        logic [NCH*32-1:0]   inst;
        logic [NCH-1:0]      wen;
        logic [NCH*8-1:0]    wdest;
        logic [NCH*XLEN-1:0] wdata;
        logic [NCH-1:0]      skip;
        logic [63:0]         icnt;
        bit                  is_trap;
        logic [7:0]          code;
        logic [XLEN-1:0]     tpc;
    } exp_t;

    exp_t        sb[$];       // groups expected on the commit port, oldest first
    bit          m_trapq[$];  // trap flag of each group the model holds
    int          m_occ   = 0;
    bit          m_trap  = 1'b0;
    logic [63:0] m_cyc   = '0;
    logic [63:0] m_icnt  = '0;
    int          pulses  = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          p0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cmt_valid", cmt_valid, 0);
        chk("rst_cmt_pc", cmt_pc, 0);
        chk("rst_cmt_inst", cmt_inst, 0);
        chk("rst_cmt_wen", cmt_wen, 0);
        chk("rst_cmt_wdest", cmt_wdest, 0);
        chk("rst_cmt_wdata", cmt_wdata, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_code", trap_code, 0);
        chk("rst_trap_pc", trap_pc, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
`ifdef DIFFTEST_SKIP_EN
        chk("rst_cmt_skip", cmt_skip, 0);
`endif
    endtask

    // Called at a falling edge with the inputs already driven; advances one rising edge.
    task automatic step();
        logic           rdy_exp;
        logic [NCH-1:0] m;
        bit             pop;
        exp_t           e;
        #1;
        chk("cycle_cnt", cycle_cnt, m_cyc);
        rdy_exp = !m_trap && (m_occ < DEPTH);
        chk("in_ready", in_ready, rdy_exp);
        pop = (m_occ > 0) && out_ready && !m_trap;
        if (!m_trap) m_cyc++;
        if (pop) begin
            m_occ--;
            if (m_trapq.pop_front()) m_trap = 1'b1;
        end
        if (in_valid && rdy_exp) begin
            m = in_lane_vld;
            if (in_pc[XLEN-1:0] == PC_START && in_inst[31:0] == 32'd0) m[0] = 1'b0;
            if (m != '0) begin
                e.mask  = m;
                e.pc    = in_pc;
                e.inst  = in_inst;
                e.wen   = in_wen;
                e.wdest = in_wdest;
                e.wdata = in_wdata;
`ifdef DIFFTEST_SKIP_EN
                e.skip  = in_skip;
`else
                e.skip  = '0;
`endif
                m_icnt  = m_icnt + 64'($countones(m));
                e.icnt  = m_icnt;
                e.code  = in_a0[7:0];
                e.is_trap = 1'b0;
                e.tpc   = '0;
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (m[i]) begin
                        e.is_trap = (in_inst[i*32 +: 7] == 7'h6b);
                        e.tpc     = in_pc[i*XLEN +: XLEN];
                    end
                end
                sb.push_back(e);
                m_trapq.push_back(e.is_trap);
                m_occ++;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        check_reset();
        sb.delete();
        m_trapq.delete();
        m_occ  = 0;
        m_trap = 1'b0;
        m_cyc  = '0;
        m_icnt = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
    endtask

    task automatic set_lane(input int i, input logic [XLEN-1:0] pc, input logic [31:0] inst);
        in_pc[i*XLEN +: XLEN] = pc;
        in_inst[i*32 +: 32]   = inst;
    endtask

    // nl < 0 picks a random contiguous lane count.
    task automatic rand_group(input int nl);
        logic [31:0] ins;
        int          n;
        n = nl;
        if (n < 0) n = $urandom_range(0, NCH);
        in_valid = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            ins = $urandom;
            if (ins[6:0] == 7'h6b) ins[0] = 1'b0;
            in_lane_vld[i]            = (i < n);
            in_inst[i*32 +: 32]       = ins;
            in_pc[i*XLEN +: XLEN]     = {32'h0, $urandom};
            in_wen[i]                 = 1'($urandom);
            in_wdest[i*8 +: 8]        = {3'd0, 5'($urandom)};
            in_wdata[i*XLEN +: XLEN]  = {$urandom, $urandom};
`ifdef DIFFTEST_SKIP_EN
            in_skip[i]                = 1'($urandom);
`endif
        end
        in_a0 = {$urandom, $urandom};
    endtask

    // Monitor: every commit pulse must match the oldest expected group.
    always @(posedge clock) begin
        exp_t e;
        #3;
        if (reset && cmt_valid != '0) begin
            pulses++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_commit: got cmt_valid %0h, expected no commit", cmt_valid);
            end else begin
                e = sb.pop_front();
                chk("mon_cmt_valid", cmt_valid, e.mask);
                chk("mon_cmt_pc", cmt_pc, e.pc);
                chk("mon_cmt_inst", cmt_inst, e.inst);
                chk("mon_cmt_wen", cmt_wen, e.wen);
                chk("mon_cmt_wdest", cmt_wdest, e.wdest);
                chk("mon_cmt_wdata", cmt_wdata, e.wdata);
                chk("mon_instr_cnt", instr_cnt, e.icnt);
`ifdef DIFFTEST_SKIP_EN
                chk("mon_cmt_skip", cmt_skip, e.skip);
`endif
                if (e.is_trap) begin
                    chk("mon_trap", trap, 1);
                    chk("mon_trap_code", trap_code, e.code);
                    chk("mon_trap_pc", trap_pc, e.tpc);
                end else begin
                    chk("mon_no_trap", trap, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check_reset();
        @(negedge clock);
        reset = 1'b1;

        // Single two-lane group, one-edge latency.
        rand_group(NCH);
        set_lane(0, 64'h8000_0000, 32'h0010_0093);
        set_lane(1, 64'h8000_0004, 32'h0020_0113);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("latency_not_yet", cmt_valid, 0);
        step();
        chk("single_cmt_valid", cmt_valid, 2'b11);
        chk("single_instr_cnt", instr_cnt, 2);

        // Backpressure: fill, refuse, then drain in order.
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            rand_group(NCH);
            step();
        end
        chk("full_in_ready", in_ready, 0);
        rand_group(NCH);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p0 = pulses;
        repeat (DEPTH) step();
        chk("drain_pulses", pulses - p0, DEPTH);
        step();
        chk("drain_empty", sb.size(), 0);

        // Push and pop in the same cycle across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            rand_group(NCH);
            in_pc[XLEN-1:0] = 64'h8000_1000 + 64'(k * 8);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("wrap_empty", sb.size(), 0);

        // Boot bubble on lane 0.
        rand_group(NCH);
        set_lane(0, PC_START, 32'h0);
        set_lane(1, 64'h8000_0004, 32'h0020_0113);
`ifdef DIFFTEST_SKIP_EN
        in_skip = 2'b10;
`endif
        step();
        in_valid = 1'b0;
        step();
        chk("bubble_cmt_valid", cmt_valid, 2'b10);
`ifdef DIFFTEST_SKIP_EN
        chk("bubble_cmt_skip", cmt_skip, 2'b10);
`endif
        rand_group(1);
        set_lane(0, PC_START, 32'h0);
        p0 = pulses;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("dropped_group", pulses - p0, 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                rand_group(-1);
                if ($urandom_range(0, 7) == 0) set_lane(0, PC_START, 32'h0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();
        chk("random_drain", sb.size(), 0);

        // Reset with three groups queued.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_group(NCH);
            step();
        end
        in_valid = 1'b0;
        do_reset();
        rand_group(NCH);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("post_reset_instr_cnt", instr_cnt, 2);

        // Trap on lane 0; the group queued behind it stays unread.
        out_ready = 1'b0;
        rand_group(NCH);
        set_lane(0, 64'h8000_2000, 32'h0000_006b);
        in_a0 = '0;
        step();
        rand_group(NCH);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("trap", trap, 1);
        chk("trap_code", trap_code, 8'h00);
        chk("trap_pc", trap_pc, 64'h8000_2000);
        p0 = pulses;
        rand_group(NCH);
        repeat (4) step();
        chk("trap_no_pop", pulses - p0, 0);
        chk("trap_retained", sb.size(), 1);
        in_valid = 1'b0;

        // Trap on lane 1 behind a boot bubble.
        do_reset();
        out_ready = 1'b1;
        rand_group(NCH);
        set_lane(0, PC_START, 32'h0);
        set_lane(1, 64'h8000_3004, 32'h0010_006b);
        in_a0 = 64'h1122_3344_5566_77a5;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("trap2_trap", trap, 1);
        chk("trap2_code", trap_code, 8'ha5);
        chk("trap2_pc", trap_pc, 64'h8000_3004);
        chk("trap2_instr_cnt", instr_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
